// File: rtl/qdrain_pkg.sv
// Shared definitions for the queue drain controller: M-field layout helpers and
// the output-buffer occupancy encoding. Build option: QDRAIN_WAKE_BYPASS_EN (see top).
package qdrain_pkg;

  // The pending flag sits in the MSB of the M field.
  function automatic int pend_bit(input int m_width);
    return m_width - 1;
  endfunction

  // While pending, the remaining M bits carry a tag. Once resolved, they carry the value.
  function automatic int tag_width(input int m_width);
    return m_width - 1;
  endfunction

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_cnt_e;

endpackage

// File: rtl/qdrain_wake_slice.sv
// One M-field wakeup comparator: rewrites a pending M field when the broadcast tag matches.
module qdrain_wake_slice
  import qdrain_pkg::*;
#(
  parameter int M_WIDTH = 8
) (
  input  logic [M_WIDTH-1:0] old_m,
  input  logic               bcast_valid,
  input  logic [M_WIDTH-2:0] bcast_tag,
  input  logic [M_WIDTH-2:0] bcast_val,
  output logic [M_WIDTH-1:0] new_m,
  output logic               modify
);

  localparam int PEND  = pend_bit(M_WIDTH);
  localparam int TAG_W = tag_width(M_WIDTH);

  always_comb begin
    modify = bcast_valid && old_m[PEND] && (old_m[TAG_W-1:0] == bcast_tag);
    new_m  = modify ? {1'b0, bcast_val} : old_m;
  end

endmodule

// File: rtl/queue_drain_ctrl.sv
// Drains the M/N queue head once its M field is resolved, into a 2-entry output buffer,
// and applies result-tag wakeups in place. Build option: QDRAIN_WAKE_BYPASS_EN.
module queue_drain_ctrl
  import qdrain_pkg::*;
#(
  parameter int M_WIDTH   = 8,
  parameter int N_WIDTH   = 8,
  parameter int Q_LENGTH  = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        q_empty,
  input  logic [M_WIDTH+N_WIDTH-1:0]  q_dout,
  input  logic [M_WIDTH*Q_LENGTH-1:0] q_old_m_vector,
  output logic                        q_rd,
  output logic [M_WIDTH*Q_LENGTH-1:0] q_new_m_vector,
  output logic [Q_LENGTH-1:0]         q_modify_vector,
  input  logic [M_WIDTH-1:0]          wr_m_in,
  output logic [M_WIDTH-1:0]          wr_m_out,
  input  logic                        bcast_valid,
  input  logic [M_WIDTH-2:0]          bcast_tag,
  input  logic [M_WIDTH-2:0]          bcast_val,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [M_WIDTH+N_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0]        head_wait_cnt
);

  localparam int PEND  = pend_bit(M_WIDTH);
  localparam int DATA_W = M_WIDTH + N_WIDTH;

  for (genvar i = 0; i < Q_LENGTH; i++) begin : g_slot
    qdrain_wake_slice #(.M_WIDTH(M_WIDTH)) u_slice (
      .old_m       (q_old_m_vector[i*M_WIDTH +: M_WIDTH]),
      .bcast_valid (bcast_valid),
      .bcast_tag   (bcast_tag),
      .bcast_val   (bcast_val),
      .new_m       (q_new_m_vector[i*M_WIDTH +: M_WIDTH]),
      .modify      (q_modify_vector[i])
    );
  end

  // The queue's load wins over modify on the same slot, so the incoming M is fixed here.
  logic [M_WIDTH-1:0] wr_fix_m;
  logic               wr_fix_hit;

  qdrain_wake_slice #(.M_WIDTH(M_WIDTH)) u_wr_fix (
    .old_m       (wr_m_in),
    .bcast_valid (bcast_valid),
    .bcast_tag   (bcast_tag),
    .bcast_val   (bcast_val),
    .new_m       (wr_fix_m),
    .modify      (wr_fix_hit)
  );

  assign wr_m_out = wr_fix_hit ? wr_fix_m : wr_m_in;

  logic [M_WIDTH-1:0] head_m;
  logic               head_pending;
  logic               eligible;
  logic               blocked;
  logic [DATA_W-1:0]  push_data;

  assign head_m       = q_dout[DATA_W-1 -: M_WIDTH];
  assign head_pending = head_m[PEND];

`ifdef QDRAIN_WAKE_BYPASS_EN
  // A head woken by this cycle's broadcast is popped right away, carrying the fresh value.
  logic head_hit;
  assign head_hit  = bcast_valid && head_pending && (head_m[M_WIDTH-2:0] == bcast_tag);
  assign eligible  = !q_empty && (!head_pending || head_hit);
  assign blocked   = !q_empty && head_pending && !head_hit;
  assign push_data = head_hit ? {1'b0, bcast_val, q_dout[N_WIDTH-1:0]} : q_dout;
`else
  assign eligible  = !q_empty && !head_pending;
  assign blocked   = !q_empty && head_pending;
  assign push_data = q_dout;
`endif

  buf_cnt_e          count, count_next;
  logic [DATA_W-1:0] buf0, buf1, buf0_next, buf1_next;
  logic              pop;

  assign out_valid = (count != BUF_EMPTY);
  assign out_data  = buf0;
  assign pop       = out_valid && out_ready;
  assign q_rd      = !clr && eligible && ((count != BUF_FULL) || out_ready);

  always_ff @(posedge clk) begin
    if (clr) begin
      count         <= BUF_EMPTY;
      buf0          <= '0;
      buf1          <= '0;
      head_wait_cnt <= '0;
    end else begin
      count <= count_next;
      buf0  <= buf0_next;
      buf1  <= buf1_next;
      if (blocked && (head_wait_cnt != '1))
        head_wait_cnt <= head_wait_cnt + CNT_WIDTH'(1);
    end
  end

  // buf0 is always the oldest entry. A simultaneous push and pop shifts buf1 forward.
  always_comb begin
    count_next = count;
    buf0_next  = buf0;
    buf1_next  = buf1;
    unique case ({q_rd, pop})
      2'b10: begin
        if (count == BUF_EMPTY) begin
          buf0_next  = push_data;
          count_next = BUF_ONE;
        end else if (count == BUF_ONE) begin
          buf1_next  = push_data;
          count_next = BUF_FULL;
        end
      end
      2'b01: begin
        buf0_next  = buf1;
        count_next = (count == BUF_FULL) ? BUF_ONE : BUF_EMPTY;
      end
      2'b11: begin
        if (count == BUF_FULL) begin
          buf0_next = buf1;
          buf1_next = push_data;
        end else begin
          buf0_next = push_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_queue_drain_ctrl.sv
// Directed, table-driven bench for queue_drain_ctrl; the bench itself plays the queue.
// Honours QDRAIN_WAKE_BYPASS_EN where the expected timing differs.
module tb_queue_drain_ctrl;

  localparam int MW = 8;
  localparam int NW = 8;
  localparam int QL = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           clr;
  logic           q_empty;
  logic [15:0]    q_dout;
  logic [31:0]    q_old_m_vector;
  logic           q_rd;
  logic [31:0]    q_new_m_vector;
  logic [3:0]     q_modify_vector;
  logic [7:0]     wr_m_in;
  logic [7:0]     wr_m_out;
  logic           bcast_valid;
  logic [6:0]     bcast_tag;
  logic [6:0]     bcast_val;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    out_data;
  logic [3:0]     head_wait_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  queue_drain_ctrl #(.M_WIDTH(MW), .N_WIDTH(NW), .Q_LENGTH(QL), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .clr             (clr),
    .q_empty         (q_empty),
    .q_dout          (q_dout),
    .q_old_m_vector  (q_old_m_vector),
    .q_rd            (q_rd),
    .q_new_m_vector  (q_new_m_vector),
    .q_modify_vector (q_modify_vector),
    .wr_m_in         (wr_m_in),
    .wr_m_out        (wr_m_out),
    .bcast_valid     (bcast_valid),
    .bcast_tag       (bcast_tag),
    .bcast_val       (bcast_val),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .head_wait_cnt   (head_wait_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        empty;
    logic [15:0] dout;
    logic        rdy;
    logic        bv;
    logic [6:0]  btag;
    logic [6:0]  bval;
    logic        exp_rd;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs [0:23];

  task automatic setVec(input int i, input logic c, input logic e, input logic [15:0] d,
                        input logic r, input logic bv, input logic [6:0] bt, input logic [6:0] bl,
                        input logic xr, input logic xv, input logic [15:0] xd, input logic [3:0] xc);
    vecs[i].clr = c;  vecs[i].empty = e; vecs[i].dout = d; vecs[i].rdy = r;
    vecs[i].bv = bv;  vecs[i].btag = bt; vecs[i].bval = bl;
    vecs[i].exp_rd = xr; vecs[i].exp_valid = xv; vecs[i].exp_data = xd; vecs[i].exp_cnt = xc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock per vector: q_rd is checked mid-cycle, registered outputs just after the edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    clr = v.clr; q_empty = v.empty; q_dout = v.dout; out_ready = v.rdy;
    bcast_valid = v.bv; bcast_tag = v.btag; bcast_val = v.bval;
    @(negedge clk);
    checkOutput($sformatf("vec%0d q_rd", idx), {31'd0, q_rd}, {31'd0, v.exp_rd});
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d out_valid", idx), {31'd0, out_valid}, {31'd0, v.exp_valid});
    checkOutput($sformatf("vec%0d head_wait_cnt", idx), {28'd0, head_wait_cnt}, {28'd0, v.exp_cnt});
    if (v.exp_valid || v.clr)
      checkOutput($sformatf("vec%0d out_data", idx), {16'd0, out_data}, {16'd0, v.exp_data});
  endtask

  initial begin
    vec_t v;
    int   start_cnt;

    //       i  clr emp dout      rdy bv tag   val    rd  vld data      cnt
    setVec( 0, 1, 0, 16'h0111, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd0);
    // plain drain
    setVec( 1, 0, 0, 16'h0111, 1, 0, 7'd0, 7'h00, 1, 1, 16'h0111, 4'd0);
    setVec( 2, 0, 0, 16'h0222, 1, 0, 7'd0, 7'h00, 1, 1, 16'h0222, 4'd0);
    setVec( 3, 0, 0, 16'h0333, 1, 0, 7'd0, 7'h00, 1, 1, 16'h0333, 4'd0);
    setVec( 4, 0, 1, 16'h0333, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd0);
    // backpressure
    setVec( 5, 0, 0, 16'h0444, 0, 0, 7'd0, 7'h00, 1, 1, 16'h0444, 4'd0);
    setVec( 6, 0, 0, 16'h0555, 0, 0, 7'd0, 7'h00, 1, 1, 16'h0444, 4'd0);
    setVec( 7, 0, 0, 16'h0666, 0, 0, 7'd0, 7'h00, 0, 1, 16'h0444, 4'd0);
    setVec( 8, 0, 0, 16'h0666, 0, 0, 7'd0, 7'h00, 0, 1, 16'h0444, 4'd0);
    setVec( 9, 0, 0, 16'h0666, 1, 0, 7'd0, 7'h00, 1, 1, 16'h0555, 4'd0);
    setVec(10, 0, 0, 16'h0777, 1, 0, 7'd0, 7'h00, 1, 1, 16'h0666, 4'd0);
    setVec(11, 0, 1, 16'h0777, 1, 0, 7'd0, 7'h00, 0, 1, 16'h0777, 4'd0);
    setVec(12, 0, 1, 16'h0777, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd0);
    // pending head on tag 5, then wakeup with 0x2A
    setVec(13, 0, 0, 16'h8599, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd1);
    setVec(14, 0, 0, 16'h8599, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd2);
    setVec(15, 0, 0, 16'h8599, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd3);
`ifdef QDRAIN_WAKE_BYPASS_EN
    setVec(16, 0, 0, 16'h8599, 1, 1, 7'd5, 7'h2A, 1, 1, 16'h2A99, 4'd3);
    setVec(17, 0, 1, 16'h2A99, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd3);
    setVec(18, 0, 1, 16'h2A99, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd3);
`else
    setVec(16, 0, 0, 16'h8599, 1, 1, 7'd5, 7'h2A, 0, 0, 16'h0000, 4'd4);
    setVec(17, 0, 0, 16'h2A99, 1, 0, 7'd0, 7'h00, 1, 1, 16'h2A99, 4'd4);
    setVec(18, 0, 1, 16'h2A99, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd4);
`endif
    // woken write pops immediately, then fill to 2 and clear mid-run
    setVec(19, 0, 0, 16'h0755, 1, 0, 7'd0, 7'h00, 1, 1, 16'h0755, 4'd15);
    setVec(20, 0, 0, 16'h0101, 0, 0, 7'd0, 7'h00, 1, 1, 16'h0755, 4'd15);
    setVec(21, 0, 0, 16'h0202, 0, 0, 7'd0, 7'h00, 0, 1, 16'h0755, 4'd15);
    setVec(22, 1, 0, 16'h0202, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd0);
    setVec(23, 0, 1, 16'h0202, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000, 4'd0);

    clr = 1'b1; q_empty = 1'b1; q_dout = '0; q_old_m_vector = '0; wr_m_in = '0;
    bcast_valid = 1'b0; bcast_tag = '0; bcast_val = '0; out_ready = 1'b1;

    for (int i = 0; i <= 18; i++) applyStimulus(vecs[i], i);

    // a head held pending long enough to saturate the counter
`ifdef QDRAIN_WAKE_BYPASS_EN
    start_cnt = 3;
`else
    start_cnt = 4;
`endif
    for (int k = 1; k <= 14; k++) begin
      setVec(0, 0, 0, 16'h8199, 1, 0, 7'd0, 7'h00, 0, 0, 16'h0000,
             4'((start_cnt + k > 15) ? 15 : start_cnt + k));
      v = vecs[0];
      applyStimulus(v, 100 + k);
    end

    // multi-match: slots {3,2,1,0} = {resolved 9, pending 9, pending 4, pending 9}
    q_empty = 1'b1;
    q_old_m_vector = 32'h09_89_84_89;
    bcast_valid = 1'b1; bcast_tag = 7'd9; bcast_val = 7'h11;
    #1;
    checkOutput("multi tag9 modify", {28'd0, q_modify_vector}, 32'h0000_0005);
    checkOutput("multi tag9 new_m", q_new_m_vector, 32'h09_11_84_11);
    bcast_tag = 7'd4; bcast_val = 7'h33;
    #1;
    checkOutput("multi tag4 modify", {28'd0, q_modify_vector}, 32'h0000_0002);
    checkOutput("multi tag4 new_m", q_new_m_vector, 32'h09_89_33_89);
    bcast_valid = 1'b0;
    #1;
    checkOutput("no bcast modify", {28'd0, q_modify_vector}, 32'h0);
    checkOutput("no bcast new_m", q_new_m_vector, 32'h09_89_84_89);

    // write collision
    wr_m_in = 8'h83; bcast_valid = 1'b1; bcast_tag = 7'd3; bcast_val = 7'd7;
    #1;
    checkOutput("wr fixup hit", {24'd0, wr_m_out}, 32'h07);
    bcast_valid = 1'b0;
    #1;
    checkOutput("wr fixup no bcast", {24'd0, wr_m_out}, 32'h83);
    wr_m_in = 8'h03; bcast_valid = 1'b1;
    #1;
    checkOutput("wr fixup resolved", {24'd0, wr_m_out}, 32'h03);
    bcast_valid = 1'b0; wr_m_in = '0; q_old_m_vector = '0;
    @(posedge clk);
    #1;

    for (int i = 19; i <= 23; i++) applyStimulus(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/queue_drain_ctrl.md
# queue_drain_ctrl

Read-side and update-side controller for the `queuenm` M/N queue. It pops the queue head only once its M field is no longer pending, and hands the popped entry downstream through a 2-entry valid/ready output buffer. It also snoops a result-tag broadcast and rewrites pending M fields in place through the queue's `modify_vector`/`new_m_vector` port. It sits between the queue and the consuming execution or issue stage.

## Interface
- `M_WIDTH`, 8: queue M-field width. Bit `M_WIDTH-1` is the pending flag; bits `M_WIDTH-2:0` hold a tag while pending and a value once resolved.
- `N_WIDTH`, 8: queue N-field width. This field is passed through untouched.
- `Q_LENGTH`, 16: queue depth. Must match the attached queue.
- `CNT_WIDTH`, 16: width of the head-blocked counter.
- `clk`  in  1  clock.
- `clr`  in  1  reset, synchronous, active-high.
- `q_empty`  in  1  queue empty flag.
- `q_dout`  in  M_WIDTH+N_WIDTH  queue head entry, laid out as {M, N}.
- `q_old_m_vector`  in  M_WIDTH*Q_LENGTH  current M field of every slot.
- `q_rd`  out  1  pop request to the queue.
- `q_new_m_vector`  out  M_WIDTH*Q_LENGTH  replacement M fields.
- `q_modify_vector`  out  Q_LENGTH  per-slot M-field load enables.
- `wr_m_in`  in  M_WIDTH  M field the producer is writing this cycle.
- `wr_m_out`  out  M_WIDTH  M field corrected for the broadcast; drives the queue `m_din`.
- `bcast_valid`  in  1  broadcast strobe.
- `bcast_tag`  in  M_WIDTH-1  broadcast tag.
- `bcast_val`  in  M_WIDTH-1  resolved value for that tag.
- `out_valid`  out  1  output buffer head is valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  M_WIDTH+N_WIDTH  output buffer head.
- `head_wait_cnt`  out  CNT_WIDTH  saturating count of cycles in which a non-empty head was blocked because it was pending.

## Operation
- **Wakeup.** Slot i matches when `bcast_valid`, pending bit = 1, and the slot's tag equals `bcast_tag`.
  - On a match: `q_modify_vector[i]` = 1 and `q_new_m_vector` slot i = {1'b0, `bcast_val`}.
  - Otherwise: `q_modify_vector[i]` = 0 and the slot output equals `q_old_m_vector` slot i.
  - All matching slots update in the same cycle.
- **Write fixup.** The queue's `ld` overrides `modify` on the same slot, so the incoming entry is corrected here instead. If `wr_m_in` is pending and its tag matches a valid broadcast, `wr_m_out` = {0, `bcast_val`}. Otherwise `wr_m_out` = `wr_m_in`.
- **Head eligibility.** The head is eligible when `!q_empty` and the head's pending bit = 0.
- **Pop condition.** `q_rd` = eligible && (buffer count < 2 || `out_ready`). `q_rd` is 0 while `clr` is high. On `q_rd`, the head is pushed into the buffer at the clock edge.
- **Output buffer.** Two-entry FIFO with count 0..2.
  - `out_data` is the oldest entry; `out_valid` = (count != 0).
  - Pop and push in the same cycle: count is unchanged and order is preserved.
  - `out_data` is held stable while `out_valid && !out_ready`.
- **Blocked counter.** `head_wait_cnt` increments on each cycle with `!q_empty` and head pending. It saturates at all-ones.

## Timing
- **Reset.** `clr` at an edge sets:
  - buffer count = 0, `out_valid` = 0, `out_data` = 0;
  - `head_wait_cnt` = 0.
- **Reset mid-operation.** `clr` discards buffered entries and does not pop; the attached queue clears on the same `clr`.
- **Latency.** An eligible head at cycle t, with buffer space available, gives `out_valid` at t+1.
- **Throughput.** One entry per cycle while `out_ready` stays high.
- **Wakeup timing.** A broadcast at t writes the slot at the edge ending t, so the entry is eligible at t+1 unless the bypass below is compiled in.
- **Combinational outputs.** `q_rd`, `q_modify_vector`, `q_new_m_vector` and `wr_m_out` are combinational from inputs and state.
- **Full buffer.** With count = 2 and `!out_ready`, `q_rd` = 0.

## Configuration
- `QDRAIN_WAKE_BYPASS_EN` defined:
  - A head that is pending but matched by this cycle's broadcast is treated as eligible.
  - The buffer captures {0, `bcast_val`, N} instead of the stale M field.
  - The cycle is not counted in `head_wait_cnt`.
  - Wakeup-to-output latency becomes 1 cycle.
- Undefined: eligibility uses only the stored pending bit, and wakeup-to-output latency is 2 cycles.

## Structure
- **Shared package `qdrain_pkg`:**
  - `PEND_BIT` index;
  - tag/value field width function of M_WIDTH;
  - buffer count encoding constants.
- **Sub-module `qdrain_wake_slice`:** one per slot, generated; does the tag compare and new_m/modify generation. The write fixup uses one extra instance.

## Test plan
- **Plain drain.** Push three non-pending entries with `out_ready`=1 → `out_data` appears in push order on consecutive cycles starting one cycle after the first head is eligible.
- **Backpressure.** Hold `out_ready`=0 with 4 eligible entries queued → exactly 2 buffered, `q_rd`=0 afterwards, `out_data` stable. Release → remaining entries drain in order.
- **Pending head, then wakeup.**
  - Head M = {1, tag 5}: `head_wait_cnt` rises 1 per cycle.
  - Broadcast tag 5, value 0x2A → slot M becomes 0x2A.
  - Output M = 0x2A, N unchanged, 2 cycles after the broadcast without the macro, 1 cycle with it.
- **Write collision.** Write M = {1, tag 3} in the same cycle as broadcast tag 3, value 7 → `wr_m_out` = {0, 7}; the entry later pops without waiting.
- **Multi-match.** Two slots pending on tag 9 plus one slot on tag 4; broadcast 9 → exactly the two tag-9 bits set in `q_modify_vector`; the tag-4 slot stays untouched.
- **Mid-run clr.** Assert `clr` with 2 entries buffered → next cycle `out_valid`=0, `head_wait_cnt`=0, `q_rd`=0 during `clr`.
